// File: rtl/shift_register_pkg.sv
// rtl/shift_register_pkg.sv - shared state type and counter width helper
package shift_register_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width: max(1, clog2(bits)), so a 2-bit frame still gets a 1-bit counter.
  function automatic int cnt_width(input int bits);
    return (bits <= 2) ? 1 : $clog2(bits);
  endfunction

endpackage

// File: rtl/shift_frame_register_bit_counter.sv
// rtl/shift_frame_register_bit_counter.sv - modulo-BITS counter with clear and terminal-count flag
module bit_counter #(
  parameter int BITS = 8,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q;

  assign tc_o    = (count_q == CW'(BITS - 1));
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= tc_o ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/shift_frame_register.sv
// rtl/shift_frame_register.sv - framed bidirectional shift register with load handshake
module shift_frame_register
  import shift_register_pkg::*;
#(
  parameter int  BITS      = 8,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int CW        = cnt_width(BITS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  input  logic            bit_in,
  output logic            bit_out,
  input  logic [BITS-1:0] DATA_in,
  input  logic            load_valid,
  output logic            load_ready,
  output logic [BITS-1:0] DATA_out,
  output logic            frame_valid,
  output logic            busy,
  output logic [CW-1:0]   bit_count
);

  state_t          state_q;
  logic [BITS-1:0] data_q;
  logic [BITS-1:0] data_shift_d;
  logic            frame_valid_q;
  logic            load_accept;
  logic            shift_en;
  logic            last_bit;

  assign load_accept = (state_q == IDLE) && load_valid;
  assign shift_en    = (state_q == SHIFT) && enable;

  always_comb begin
    data_shift_d = MSB_FIRST ? {data_q[BITS-2:0], bit_in} : {bit_in, data_q[BITS-1:1]};
  end

  bit_counter #(
    .BITS (BITS),
    .CW   (CW)
  ) u_bit_counter (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (load_accept),
    .inc_i   (shift_en),
    .count_o (bit_count),
    .tc_o    (last_bit)
  );

  // Load only in IDLE, so a load always wins over a same-cycle enable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      data_q        <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            data_q  <= DATA_in;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            data_q <= data_shift_d;
            if (last_bit) begin
              state_q       <= IDLE;
              frame_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bit_out     = MSB_FIRST ? data_q[BITS-1] : data_q[0];
  assign DATA_out    = data_q;
  assign frame_valid = frame_valid_q;
  assign load_ready  = (state_q == IDLE);
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_shift_frame_register.sv
// tb/tb_shift_frame_register.sv - directed self-checking bench for shift_frame_register
module tb_shift_frame_register;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // LSB-first, 8 bits
  logic       en_l = 0, bi_l = 0, lv_l = 0;
  logic [7:0] din_l = '0;
  logic       bo_l, lr_l, fv_l, busy_l;
  logic [7:0] dout_l;
  logic [2:0] bc_l;

  // MSB-first, 8 bits
  logic       en_m = 0, bi_m = 0, lv_m = 0;
  logic [7:0] din_m = '0;
  logic       bo_m, lr_m, fv_m, busy_m;
  logic [7:0] dout_m;
  logic [2:0] bc_m;

  // LSB-first, 2 bits
  logic       en_2 = 0, bi_2 = 0, lv_2 = 0;
  logic [1:0] din_2 = '0;
  logic       bo_2, lr_2, fv_2, busy_2;
  logic [1:0] dout_2;
  logic [0:0] bc_2;

  // MSB-first, 13 bits
  logic        en_d = 0, bi_d = 0, lv_d = 0;
  logic [12:0] din_d = '0;
  logic        bo_d, lr_d, fv_d, busy_d;
  logic [12:0] dout_d;
  logic [3:0]  bc_d;

  shift_frame_register #(.BITS(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .clk(clk), .rstn(rstn), .enable(en_l), .bit_in(bi_l), .bit_out(bo_l),
    .DATA_in(din_l), .load_valid(lv_l), .load_ready(lr_l), .DATA_out(dout_l),
    .frame_valid(fv_l), .busy(busy_l), .bit_count(bc_l));

  shift_frame_register #(.BITS(8), .MSB_FIRST(1'b1)) u_msb8 (
    .clk(clk), .rstn(rstn), .enable(en_m), .bit_in(bi_m), .bit_out(bo_m),
    .DATA_in(din_m), .load_valid(lv_m), .load_ready(lr_m), .DATA_out(dout_m),
    .frame_valid(fv_m), .busy(busy_m), .bit_count(bc_m));

  shift_frame_register #(.BITS(2), .MSB_FIRST(1'b0)) u_w2 (
    .clk(clk), .rstn(rstn), .enable(en_2), .bit_in(bi_2), .bit_out(bo_2),
    .DATA_in(din_2), .load_valid(lv_2), .load_ready(lr_2), .DATA_out(dout_2),
    .frame_valid(fv_2), .busy(busy_2), .bit_count(bc_2));

  shift_frame_register #(.BITS(13), .MSB_FIRST(1'b1)) u_w13 (
    .clk(clk), .rstn(rstn), .enable(en_d), .bit_in(bi_d), .bit_out(bo_d),
    .DATA_in(din_d), .load_valid(lv_d), .load_ready(lr_d), .DATA_out(dout_d),
    .frame_valid(fv_d), .busy(busy_d), .bit_count(bc_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0; lv_l = 1; en_l = 1; din_l = 8'hFF;
    tick(); tick();
    total++; if (dout_l !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", dout_l); end
    total++; if (lr_l !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%b exp=1", lr_l); end
    total++; if (busy_l !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_l); end
    total++; if (fv_l !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b exp=0", fv_l); end
    total++; if (bo_l !== 1'b0) begin bad++; $display("FAIL reset_bit_out got=%b exp=0", bo_l); end
    lv_l = 0; en_l = 0; rstn = 1;
    tick();
  endtask

  task automatic test_load_with_enable();
    din_l = 8'h3C; lv_l = 1; en_l = 1; bi_l = 1;
    tick();
    lv_l = 0; en_l = 0;
    total++; if (bc_l !== 3'd0) begin bad++; $display("FAIL ld_en_count got=%0d exp=0", bc_l); end
    total++; if (dout_l !== 8'h3C) begin bad++; $display("FAIL ld_en_data got=%h exp=3c", dout_l); end
    total++; if (busy_l !== 1'b1) begin bad++; $display("FAIL ld_en_busy got=%b exp=1", busy_l); end
    // finish this frame with zeros shifted in
    bi_l = 0;
    for (int i = 0; i < 8; i++) begin en_l = 1; tick(); end
    en_l = 0;
    total++; if (fv_l !== 1'b1 || dout_l !== 8'h00) begin bad++; $display("FAIL ld_en_end fv=%b data=%h exp fv=1 data=00", fv_l, dout_l); end
    tick();
  endtask

  task automatic test_tx_lsb();
    logic [7:0] word;
    int pulses;
    word = 8'hA5; pulses = 0;
    din_l = word; lv_l = 1; bi_l = 0;
    tick();
    lv_l = 0;
    total++; if (busy_l !== 1'b1 || lr_l !== 1'b0) begin bad++; $display("FAIL tx_start busy=%b ready=%b exp 1/0", busy_l, lr_l); end
    for (int i = 0; i < 8; i++) begin
      total++; if (bo_l !== word[i]) begin bad++; $display("FAIL tx_bit%0d got=%b exp=%b", i, bo_l, word[i]); end
      en_l = 0; tick();
      if (fv_l) pulses++;
      en_l = 1; tick();
      if (fv_l) pulses++;
      en_l = 0;
    end
    total++; if (fv_l !== 1'b1 || busy_l !== 1'b0 || lr_l !== 1'b1) begin bad++; $display("FAIL tx_done fv=%b busy=%b ready=%b exp 1/0/1", fv_l, busy_l, lr_l); end
    total++; if (dout_l !== 8'h00) begin bad++; $display("FAIL tx_final_data got=%h exp=00", dout_l); end
    tick();
    if (fv_l) pulses++;
    total++; if (pulses !== 1) begin bad++; $display("FAIL tx_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_rx_msb();
    logic [7:0] bits;
    bits = 8'b1100_1010;
    din_m = 8'h00; lv_m = 1;
    tick();
    lv_m = 0;
    for (int i = 0; i < 8; i++) begin
      bi_m = bits[7-i]; en_m = 1; tick(); en_m = 0;
      if (i == 2) begin
        din_m = 8'hFF; lv_m = 1; tick(); lv_m = 0;
        total++; if (dout_m !== 8'h06) begin bad++; $display("FAIL rx_load_ignored got=%h exp=06", dout_m); end
        total++; if (bc_m !== 3'd3) begin bad++; $display("FAIL rx_count_hold got=%0d exp=3", bc_m); end
      end
      if (i < 7) begin
        total++; if (fv_m !== 1'b0) begin bad++; $display("FAIL rx_early_fv at shift %0d got=%b exp=0", i, fv_m); end
      end
    end
    total++; if (fv_m !== 1'b1 || dout_m !== 8'hCA) begin bad++; $display("FAIL rx_word fv=%b data=%h exp fv=1 data=ca", fv_m, dout_m); end
    // load in the frame_valid cycle starts the next frame
    din_m = 8'h5A; lv_m = 1;
    tick();
    lv_m = 0;
    total++; if (busy_m !== 1'b1 || dout_m !== 8'h5A || fv_m !== 1'b0) begin bad++; $display("FAIL b2b_load busy=%b data=%h fv=%b exp 1/5a/0", busy_m, dout_m, fv_m); end
    total++; if (bo_m !== 1'b0) begin bad++; $display("FAIL b2b_bit_out got=%b exp=0", bo_m); end
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    pulses = 0;
    din_l = 8'h3C; lv_l = 1; tick(); lv_l = 0;
    for (int i = 0; i < 3; i++) begin en_l = 1; tick(); end
    en_l = 0;
    rstn = 0; tick(); if (fv_l) pulses++;
    total++; if (dout_l !== 8'h00 || busy_l !== 1'b0 || bc_l !== 3'd0) begin bad++; $display("FAIL midrst data=%h busy=%b cnt=%0d exp 00/0/0", dout_l, busy_l, bc_l); end
    rstn = 1; tick(); if (fv_l) pulses++;
    tick(); if (fv_l) pulses++;
    total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_fv got=%0d exp=0", pulses); end
    din_l = 8'h81; lv_l = 1; bi_l = 1; tick(); lv_l = 0;
    for (int i = 0; i < 8; i++) begin en_l = 1; tick(); end
    en_l = 0; bi_l = 0;
    total++; if (fv_l !== 1'b1 || dout_l !== 8'hFF) begin bad++; $display("FAIL midrst_next fv=%b data=%h exp 1/ff", fv_l, dout_l); end
    tick();
  endtask

  task automatic test_width_sweep();
    din_2 = 2'b10; lv_2 = 1; bi_2 = 1; tick(); lv_2 = 0;
    total++; if (bo_2 !== 1'b0) begin bad++; $display("FAIL w2_bit0 got=%b exp=0", bo_2); end
    en_2 = 1; tick();
    total++; if (fv_2 !== 1'b0 || bc_2 !== 1'b1 || bo_2 !== 1'b1) begin bad++; $display("FAIL w2_mid fv=%b cnt=%0d bo=%b exp 0/1/1", fv_2, bc_2, bo_2); end
    tick(); en_2 = 0;
    total++; if (fv_2 !== 1'b1 || bc_2 !== 1'b0 || dout_2 !== 2'b11) begin bad++; $display("FAIL w2_end fv=%b cnt=%0d data=%b exp 1/0/11", fv_2, bc_2, dout_2); end

    din_d = 13'h0001; lv_d = 1; bi_d = 1; tick(); lv_d = 0;
    total++; if (bo_d !== 1'b0) begin bad++; $display("FAIL w13_bit0 got=%b exp=0", bo_d); end
    for (int i = 0; i < 13; i++) begin
      en_d = 1; tick();
      if (i < 12) begin
        total++; if (fv_d !== 1'b0 || bc_d !== 4'(i + 1)) begin bad++; $display("FAIL w13_step%0d fv=%b cnt=%0d exp 0/%0d", i, fv_d, bc_d, i + 1); end
      end
    end
    en_d = 0;
    total++; if (fv_d !== 1'b1 || bc_d !== 4'd0 || dout_d !== 13'h1FFF) begin bad++; $display("FAIL w13_end fv=%b cnt=%0d data=%h exp 1/0/1fff", fv_d, bc_d, dout_d); end
    tick();
    total++; if (fv_d !== 1'b0 || lr_d !== 1'b1) begin bad++; $display("FAIL w13_after fv=%b ready=%b exp 0/1", fv_d, lr_d); end
  endtask

  initial begin
    test_reset();
    test_load_with_enable();
    test_tx_lsb();
    test_rx_msb();
    test_reset_mid_frame();
    test_width_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_frame_register.md
# shift_frame_register

Parametrised, framed successor to the plain shift register, used in the USB3300 sniffer data path. One bidirectional shift core serialises a loaded word (TX) and, in the same frame, deserialises incoming bits (RX). It adds selectable bit order, a frame bit counter, a load handshake, and a one-cycle frame-complete strobe. It sits between the byte-wide capture/FIFO logic and the serial line logic (UART TX/RX bit timing), which drives `enable` once per bit period.

## Interface
- `BITS`, 8: frame/register width; legal range ≥ 2.
- `MSB_FIRST`, 0: 0 = LSB shifted out first; 1 = MSB shifted out first.
- `clk` input 1: master clock, all logic on rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `enable` input 1: shift tick; one shift per cycle high while in SHIFT.
- `bit_in` input 1: serial bit entering the register on each shift.
- `bit_out` output 1: next bit to leave (DATA[0] if LSB-first, DATA[BITS-1] if MSB-first); combinational from register.
- `DATA_in` input BITS: word to load at frame start.
- `load_valid` input 1: request to load `DATA_in` and start a frame.
- `load_ready` output 1: high in IDLE only.
- `DATA_out` output BITS: live register contents.
- `frame_valid` output 1: one-cycle pulse; `DATA_out` holds the completed frame this cycle.
- `busy` output 1: high in SHIFT.
- `bit_count` output CW: shifts done in current frame, CW = max(1, clog2(BITS)).

## Operation
- Reset (rstn low at clk edge): DATA = 0, bit_count = 0, state IDLE, frame_valid = 0. Outputs: load_ready 1, busy 0, bit_out 0, DATA_out 0. Reset mid-frame aborts the frame with no frame_valid.
- States: IDLE, SHIFT.
- IDLE: register holds; `enable` ignored. `load_valid && load_ready` → DATA <= DATA_in, bit_count <= 0, go SHIFT. Load wins over a simultaneous `enable`; no shift that cycle.
- SHIFT on `enable`:
  - LSB-first: DATA <= {bit_in, DATA[BITS-1:1]}.
  - MSB-first: DATA <= {DATA[BITS-2:0], bit_in}.
  - bit_count increments.
- SHIFT without `enable`: everything holds; `load_valid` ignored (load_ready low, request not latched).
- Last shift (enable while bit_count == BITS-1): bit_count <= 0, go IDLE, frame_valid <= 1 next cycle.
- Pure RX: load all-zero (or any) word, then shift BITS times; DATA_out at frame_valid is the received word.
- Pure TX: `bit_out` is valid from the load cycle on; the line side samples it before each `enable`.

## Timing
- Load → busy high and load_ready low on the next cycle. `bit_out` shows the first bit in the cycle after load.
- Each `enable` in SHIFT → DATA and `bit_out` update on the next cycle.
- Final `enable` → next cycle: frame_valid = 1, busy = 0, load_ready = 1, DATA_out = final word.
- A load accepted in that same cycle (frame_valid high) starts the next frame. Back-to-back frames cost 1 idle cycle.
- Minimum frame length: 1 load cycle + BITS enable cycles.
- frame_valid is exactly one cycle wide and never asserts outside a completed frame.

## Structure
- Package `shift_register_pkg`:
  - state enum {IDLE, SHIFT}.
  - `cnt_width(BITS)` function returning CW.
- Sub-module `bit_counter` (parametrised modulo-BITS counter with clear, increment and terminal-count flag). The FSM and shift datapath stay in the top.

## Test plan
- Reset: hold rstn=0 with load_valid=1 and enable=1 → DATA_out=0, load_ready=1, busy=0, frame_valid=0.
- TX LSB-first, BITS=8: load 0xA5, then 8 enables with gaps → bit_out sequence 1,0,1,0,0,1,0,1. One frame_valid pulse after the 8th enable.
- RX MSB-first, BITS=8: load 0x00, shift in 1,1,0,0,1,0,1,0 → DATA_out=0xCA at frame_valid.
- Simultaneous events:
  - load_valid and enable in the same IDLE cycle → no shift, bit_count=0.
  - load_valid during SHIFT → ignored, DATA unchanged.
  - Load in the frame_valid cycle → next frame starts.
- Reset mid-frame: rstn=0 after 3 shifts → IDLE, DATA=0, no frame_valid; the next load works normally.
- Width sweep BITS=2 and BITS=13: frame_valid only after exactly BITS enables; bit_count wraps to 0.
